board_input_conditioner: RTL and testbench



---
 rtl/board_input_conditioner.sv | 112 +++++++++++
 tb/tb_board_input_conditioner.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/board_input_conditioner.sv
// Board input front end: synchronizes and debounces slide switches and push
// buttons, and keeps sticky press/release flags plus a press counter for the host.
module board_input_conditioner #(
  parameter int N_SW            = 16,
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SW-1:0]   sw_in,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              ack_toggle,
  output logic [N_SW-1:0]   sw_state,
  output logic [31:0]       btn_word,
  output logic              event_pending
);

  // Switches occupy the low bits, buttons the high bits of one debounced vector.
  localparam int NB = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [NB-1:0]    RAW_RST  = {{N_BTN{BTN_ACTIVE_LOW}}, {N_SW{1'b0}}};
  localparam logic [N_BTN-1:0] BTN_POL  = {N_BTN{BTN_ACTIVE_LOW}};
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NB-1:0]    raw_s1, raw_s2;
  logic             ack_s1, ack_s2, ack_prev, ack_edge;
  logic [NB-1:0]    stable, stable_next;
  logic [CW-1:0]    cnt      [NB];
  logic [CW-1:0]    cnt_next [NB];
  logic [N_BTN-1:0] pressed, pressed_next, press_evt, release_evt;
  logic [N_BTN-1:0] press_flag, release_flag;
  logic [7:0]       press_cnt, press_inc;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_s1   <= RAW_RST;
      raw_s2   <= RAW_RST;
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_prev <= 1'b0;
    end else begin
      raw_s1   <= {btn_in, sw_in};
      raw_s2   <= raw_s1;
      ack_s1   <= ack_toggle;
      ack_s2   <= ack_s1;
      ack_prev <= ack_s2;
    end
  end

  assign ack_edge = ack_s2 ^ ack_prev;

  // Per-bit qualifier: counter > 0 means a level change is being qualified.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    stable_next = stable;
    for (int i = 0; i < NB; i++) begin
      cnt_next[i] = '0;
      if (raw_s2[i] != stable[i]) begin
        if (cnt[i] == CNT_LAST) stable_next[i] = raw_s2[i];
        else                    cnt_next[i]    = cnt[i] + CW'(1);
      end
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= RAW_RST;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      stable <= stable_next;
      for (int i = 0; i < NB; i++) cnt[i] <= cnt_next[i];
    end
  end

  assign pressed      = stable[NB-1:N_SW] ^ BTN_POL;
  assign pressed_next = stable_next[NB-1:N_SW] ^ BTN_POL;
  assign press_evt    = pressed_next & ~pressed;
  assign release_evt  = ~pressed_next & pressed;

  always_comb begin
    press_inc = '0;
    for (int i = 0; i < N_BTN; i++) press_inc = press_inc + 8'(press_evt[i]);
  end

  // A new event on the ack cycle survives: set is OR-ed after the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      press_flag   <= '0;
      release_flag <= '0;
      press_cnt    <= '0;
    end else begin
      press_flag   <= (ack_edge ? '0 : press_flag)   | press_evt;
      release_flag <= (ack_edge ? '0 : release_flag) | release_evt;
      press_cnt    <= press_cnt + press_inc;
    end
  end

  always_comb begin
    btn_word                  = '0;
    btn_word[N_BTN-1:0]       = pressed;
    btn_word[8 +: N_BTN]      = press_flag;
    btn_word[16 +: N_BTN]     = release_flag;
    btn_word[31:24]           = press_cnt;
  end

  assign sw_state      = stable[N_SW-1:0];
  assign event_pending = |{press_flag, release_flag};

endmodule

// File: tb/tb_board_input_conditioner.sv
// Self-checking bench for board_input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_board_input_conditioner;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic [15:0] sw_in      = '0;
  logic [3:0]  btn_in     = 4'hF;
  logic        ack_toggle = 1'b0;
  logic [15:0] sw_state;
  logic [31:0] btn_word;
  logic        event_pending;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [3:0]  btn;
    logic [15:0] sw;
    logic        ack;
    int          cycles;
    logic [31:0] exp_btn;
    logic [15:0] exp_sw;
    logic        exp_pend;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] btn;
    logic [15:0] sw;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  board_input_conditioner #(
    .N_SW(16), .N_BTN(4), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .sw_in(sw_in), .btn_in(btn_in),
    .ack_toggle(ack_toggle), .sw_state(sw_state), .btn_word(btn_word),
    .event_pending(event_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string name, input logic [3:0] btn, input logic [15:0] sw,
                             input logic ack, input int cycles, input logic [31:0] exp_btn,
                             input logic [15:0] exp_sw, input logic exp_pend);
    vec_t t;
    t.name = name; t.btn = btn; t.sw = sw; t.ack = ack; t.cycles = cycles;
    t.exp_btn = exp_btn; t.exp_sw = exp_sw; t.exp_pend = exp_pend;
    return t;
  endfunction

  // Drive at a falling edge, let `cycles` rising edges pass, compare at the next falling edge.
  task automatic apply(input vec_t t);
    exp_t e;
    btn_in     = t.btn;
    sw_in      = t.sw;
    ack_toggle = t.ack;
    sb.push_back('{t.name, t.exp_btn, t.exp_sw, t.exp_pend});
    repeat (t.cycles) @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".btn_word"}, btn_word, e.btn);
    check({e.name, ".sw_state"}, {16'h0, sw_state}, {16'h0, e.sw});
    check({e.name, ".event_pending"}, 32'(event_pending), 32'(e.pend));
  endtask

  initial begin
    int  cnt;
    logic rel;

    // Reset held with buttons released
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_held.btn_word", btn_word, 32'h0);
    check("reset_held.sw_state", {16'h0, sw_state}, 32'h0);
    check("reset_held.event_pending", 32'(event_pending), 32'h0);
    reset = 1'b0;

    //                name              btn    sw       ack cyc exp_btn        exp_sw   pend
    tbl.push_back(v("rst_idle",        4'hF, 16'h0000, 0, 3, 32'h00000000, 16'h0000, 0));
    tbl.push_back(v("press_early",     4'hE, 16'h0000, 0, 5, 32'h00000000, 16'h0000, 0));
    tbl.push_back(v("press_accept",    4'hE, 16'h0000, 0, 1, 32'h01000101, 16'h0000, 1));
    tbl.push_back(v("press_hold",      4'hE, 16'h0000, 0, 14, 32'h01000101, 16'h0000, 1));
    tbl.push_back(v("release_early",   4'hF, 16'h0000, 0, 5, 32'h01000101, 16'h0000, 1));
    tbl.push_back(v("release_accept",  4'hF, 16'h0000, 0, 1, 32'h01010100, 16'h0000, 1));
    tbl.push_back(v("ack_wait",        4'hF, 16'h0000, 1, 2, 32'h01010100, 16'h0000, 1));
    tbl.push_back(v("ack_clear",       4'hF, 16'h0000, 1, 1, 32'h01000000, 16'h0000, 0));
    tbl.push_back(v("ack_again",       4'hF, 16'h0000, 0, 4, 32'h01000000, 16'h0000, 0));
    for (int p = 0; p < 3; p++) begin
      tbl.push_back(v("bounce_hi",     4'hF, 16'h0008, 0, 3, 32'h01000000, 16'h0000, 0));
      tbl.push_back(v("bounce_lo",     4'hF, 16'h0000, 0, 2, 32'h01000000, 16'h0000, 0));
    end
    tbl.push_back(v("sw_hold_early",   4'hF, 16'h0008, 0, 5, 32'h01000000, 16'h0000, 0));
    tbl.push_back(v("sw_accept",       4'hF, 16'h0008, 0, 1, 32'h01000000, 16'h0008, 0));
    tbl.push_back(v("b1_press",        4'hD, 16'h0008, 0, 6, 32'h02000202, 16'h0008, 1));
    tbl.push_back(v("b1_release",      4'hF, 16'h0008, 0, 6, 32'h02020200, 16'h0008, 1));
    tbl.push_back(v("b2_qualify",      4'hB, 16'h0008, 0, 3, 32'h02020200, 16'h0008, 1));
    tbl.push_back(v("b2_ack_wait",     4'hB, 16'h0008, 1, 2, 32'h02020200, 16'h0008, 1));
    tbl.push_back(v("b2_ack_collide",  4'hB, 16'h0008, 1, 1, 32'h03000404, 16'h0008, 1));
    tbl.push_back(v("b2_release",      4'hF, 16'h0008, 1, 6, 32'h03040400, 16'h0008, 1));
    tbl.push_back(v("b2_ack",          4'hF, 16'h0008, 0, 3, 32'h03000000, 16'h0008, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Preload the counter to 254 with single presses of button 0
    cnt = 3;
    rel = 1'b0;
    while (cnt != 254) begin
      cnt++;
      apply(v("preload_press", 4'hE, 16'h0008, 0, 6,
              {8'(cnt), 7'h0, rel, 8'h01, 8'h01}, 16'h0008, 1));
      rel = 1'b1;
      apply(v("preload_release", 4'hF, 16'h0008, 0, 6,
              {8'(cnt), 8'h01, 8'h01, 8'h00}, 16'h0008, 1));
    end
    apply(v("wrap_ack",       4'hF, 16'h0008, 1, 3, 32'hFE000000, 16'h0008, 0));
    apply(v("wrap_early",     4'h8, 16'h0008, 1, 5, 32'hFE000000, 16'h0008, 0));
    apply(v("wrap_accept",    4'h8, 16'h0008, 1, 1, 32'h01000707, 16'h0008, 1));
    apply(v("wrap_release",   4'hF, 16'h0008, 1, 6, 32'h01070700, 16'h0008, 1));

    // Reset in the middle of qualifying a button 3 press, switch 3 held through reset
    apply(v("midq_qualify",   4'h7, 16'h0008, 1, 3, 32'h01070700, 16'h0008, 1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midq_reset.btn_word", btn_word, 32'h0);
    check("midq_reset.sw_state", {16'h0, sw_state}, 32'h0);
    check("midq_reset.event_pending", 32'(event_pending), 32'h0);
    btn_in = 4'hF;
    reset  = 1'b0;
    apply(v("pwrup_sw_early", 4'hF, 16'h0008, 1, 5, 32'h00000000, 16'h0000, 0));
    apply(v("pwrup_sw_accept", 4'hF, 16'h0008, 1, 1, 32'h00000000, 16'h0008, 0));
    apply(v("midq_no_event",  4'hF, 16'h0008, 1, 4, 32'h00000000, 16'h0008, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
